pipe_stage_buf: RTL and testbench

Parametrised elastic pipeline-stage register for the MIPS5 core. It replaces fixed-width stage latches with a DEPTH-entry buffer that carries an arbitrary-width payload under a valid/ready handshake. Flush inserts a NOP bubble that preserves selected fields, such as the PC+4 slot. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB); stall is expressed through back-pressure instead of a dedicated input.

---
 rtl/pipe_stage_buf.sv | 87 ++++++++
 tb/tb_pipe_stage_buf.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic pipeline-stage register. A DEPTH-entry circular
// buffer carries an arbitrary-width payload under valid/ready. Flush drops
// every entry and leaves a single NOP bubble whose KEEP_MASK bits (e.g. the
// PC+4 slot) are taken from the incoming payload.
module pipe_stage_buf #(
  parameter int unsigned        DATA_W    = 181,
  parameter int unsigned        DEPTH     = 2,
  parameter logic [DATA_W-1:0]  NOP_VALUE = DATA_W'({16'h0000, 96'b0, 5'b0, 32'hBFC0_0004, 32'h0000_0000}),
  parameter logic [DATA_W-1:0]  KEEP_MASK = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_bubble,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic              mem_bub  [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] bubble_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake decode and head-of-buffer presentation.
  always_comb begin
    in_ready    = (count < CW'(DEPTH)) | out_ready;
    out_valid   = (count != '0);
    push        = in_valid & in_ready & ~flush;
    pop         = out_valid & out_ready & ~flush;
    bubble_data = (in_data & KEEP_MASK) | (NOP_VALUE & ~KEEP_MASK);
    out_data    = NOP_VALUE;
    out_bubble  = 1'b0;
    if (count != '0) begin
      out_data   = mem_data[rd_ptr];
      out_bubble = mem_bub[rd_ptr];
    end
  end

  // Storage, pointers and occupancy; reset beats flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_bub[i]  <= 1'b0;
      end
    end else if (flush) begin
      mem_data[0] <= bubble_data;
      mem_bub[0]  <= 1'b1;
      rd_ptr      <= '0;
      wr_ptr      <= ptr_inc('0);
      count       <= CW'(1);
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= in_data;
        mem_bub[wr_ptr]  <= 1'b0;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed testbench for pipe_stage_buf: three instances (DEPTH 1, 2, 3)
// share one set of inputs; each phase checks the instance it exercises.
module tb_pipe_stage_buf;

  localparam int unsigned DW = 181;
  localparam logic [DW-1:0] NOP  = {16'h0000, 96'b0, 5'b0, 32'hBFC0_0004, 32'h0000_0000};
  localparam logic [DW-1:0] KEEP = {117'b0, 32'hFFFF_FFFF, 32'h0000_0000};

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;

  logic          ir1, ov1, ob1;
  logic [DW-1:0] od1;
  logic [0:0]    cnt1;
  logic          ir2, ov2, ob2;
  logic [DW-1:0] od2;
  logic [1:0]    cnt2;
  logic          ir3, ov3, ob3;
  logic [DW-1:0] od3;
  logic [1:0]    cnt3;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  logic [DW-1:0] flush_in;
  logic [DW-1:0] flush_exp;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(DW), .DEPTH(1), .NOP_VALUE(NOP), .KEEP_MASK(KEEP)) u_d1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .out_bubble(ob1), .count(cnt1));

  pipe_stage_buf #(.DATA_W(DW), .DEPTH(2), .NOP_VALUE(NOP), .KEEP_MASK(KEEP)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir2),
    .in_data(in_data), .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
    .out_bubble(ob2), .count(cnt2));

  pipe_stage_buf #(.DATA_W(DW), .DEPTH(3), .NOP_VALUE(NOP), .KEEP_MASK(KEEP)) u_d3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir3),
    .in_data(in_data), .out_valid(ov3), .out_ready(out_ready), .out_data(od3),
    .out_bubble(ob3), .count(cnt3));

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

    // Reset held two cycles.
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_ov2",  DW'(ov2),  DW'(1'b0));
    check("rst_cnt2", DW'(cnt2), DW'(0));
    check("rst_ir2",  DW'(ir2),  DW'(1'b1));
    check("rst_od2",  od2,       NOP);
    check("rst_ob2",  DW'(ob2),  DW'(1'b0));
    check("rst_cnt1", DW'(cnt1), DW'(0));
    check("rst_cnt3", DW'(cnt3), DW'(0));

    // Back-to-back stream, downstream always ready.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      in_data = DW'(k);
      tick();
      check("strm_od2",  od2,       DW'(k));
      check("strm_ov2",  DW'(ov2),  DW'(1'b1));
      check("strm_cnt2", DW'(cnt2), DW'(1));
      check("strm_od1",  od1,       DW'(k));
      check("strm_ir1",  DW'(ir1),  DW'(1'b1));
    end
    in_valid = 1'b0;
    tick();
    check("drain_cnt2", DW'(cnt2), DW'(0));
    check("drain_od2",  od2,       NOP);

    // Back-pressure and wrap on DEPTH=3 from a fresh reset.
    rst = 1'b1; tick(); rst = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data = DW'(32'hA); tick();
    in_data = DW'(32'hB); tick();
    in_data = DW'(32'hC); tick();
    check("bp_cnt3", DW'(cnt3), DW'(3));
    check("bp_ir3",  DW'(ir3),  DW'(1'b0));
    check("bp_od3",  od3,       DW'(32'hA));
    in_data = DW'(32'hD); tick();
    check("hold_cnt3", DW'(cnt3), DW'(3));
    check("hold_od3",  od3,       DW'(32'hA));
    check("hold_ov3",  DW'(ov3),  DW'(1'b1));
    out_ready = 1'b1;
    #1;
    check("full_ir3", DW'(ir3), DW'(1'b1));
    tick();
    check("full_cnt3", DW'(cnt3), DW'(3));
    check("full_od3B", od3,       DW'(32'hB));
    in_valid = 1'b0;
    tick();
    check("dr_od3C",  od3,       DW'(32'hC));
    check("dr_cnt3",  DW'(cnt3), DW'(2));
    tick();
    check("dr_od3D",  od3,       DW'(32'hD));
    check("dr_cnt3b", DW'(cnt3), DW'(1));
    tick();
    check("dr_empty", DW'(cnt3), DW'(0));
    check("dr_ov3",   DW'(ov3),  DW'(1'b0));

    // Flush with two entries held: bubble keeps bits [63:32] of in_data.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data = DW'(32'h11); tick();
    in_data = DW'(32'h22); tick();
    check("pre_fl_cnt3", DW'(cnt3), DW'(2));
    flush_in = '1;
    flush_in[63:32] = 32'h0040_0010;
    flush_exp = NOP;
    flush_exp[63:32] = 32'h0040_0010;
    flush = 1'b1;
    in_data = flush_in;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check("fl_cnt3", DW'(cnt3), DW'(1));
    check("fl_ov3",  DW'(ov3),  DW'(1'b1));
    check("fl_ob3",  DW'(ob3),  DW'(1'b1));
    check("fl_od3",  od3,       flush_exp);
    check("fl_cnt1", DW'(cnt1), DW'(1));
    check("fl_od1",  od1,       flush_exp);

    // A push after the flush lands behind the bubble.
    in_valid = 1'b1;
    in_data  = DW'(32'h55);
    tick();
    in_valid = 1'b0;
    check("pf_cnt3", DW'(cnt3), DW'(2));
    check("pf_ob3",  DW'(ob3),  DW'(1'b1));
    out_ready = 1'b1;
    tick();
    check("pf_od3",  od3,       DW'(32'h55));
    check("pf_ob3b", DW'(ob3),  DW'(1'b0));
    check("pf_cnt3b", DW'(cnt3), DW'(1));
    tick();
    check("pf_empty", DW'(cnt3), DW'(0));

    // Flush and reset together: reset wins, no bubble.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'(32'h77);
    tick();
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    #1;
    check("fr_cnt3", DW'(cnt3), DW'(0));
    check("fr_ov3",  DW'(ov3),  DW'(1'b0));
    check("fr_ob3",  DW'(ob3),  DW'(1'b0));
    check("fr_od3",  od3,       NOP);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
